// File: rtl/axi_slv_rd_scheduler.sv
// Purpose: AXI slave read scheduler; table of outstanding AR requests, R bursts arbitrated round-robin across IDs, in-order within an ID.
// Latency: AR handshake at edge T -> first R beat valid after edge T+1; back-to-back beats with no bubble while eligible work remains.
// Backpressure: out_rid/out_rdata/out_rlast held while out_rvalid && !in_rready; out_arready drops when every table slot is valid.
// Build option: define R_INTERLEAVE_EN to re-arbitrate after every beat (different-ID bursts interleave); default locks onto a burst until rlast.
module axi_slv_rd_scheduler #(
   parameter int AXI_ID_W        = 4,
   parameter int AXI_DATA_W      = 32,
   parameter int SLV_OSTDREQ_NUM = 4
) (
   input  logic                               aclk,
   input  logic                               aresetn,
   input  logic                               in_arvalid,
   output logic                               out_arready,
   input  logic [AXI_ID_W-1:0]                in_arid,
   input  logic [3:0]                         in_arlen,
   output logic                               out_rvalid,
   input  logic                               in_rready,
   output logic [AXI_ID_W-1:0]                out_rid,
   output logic [AXI_DATA_W-1:0]              out_rdata,
   output logic [1:0]                         out_rresp,
   output logic                               out_rlast,
   output logic [$clog2(SLV_OSTDREQ_NUM):0]   out_ostd_cnt
);

   localparam int N     = SLV_OSTDREQ_NUM;
   localparam int IW    = $clog2(SLV_OSTDREQ_NUM);
   localparam int PAY_W = AXI_ID_W + 6;

   typedef enum logic {R_IDLE, R_BUSY} rstate_e;

   // Outstanding request table; older_q[i][j] means entry i was accepted before entry j.
   logic [N-1:0]          vld_q;
   logic [AXI_ID_W-1:0]   id_q    [N];
   logic [3:0]            len_q   [N];
   logic [3:0]            cnt_q   [N];
   logic [N-1:0]          older_q [N];
   logic [IW-1:0]         ptr_q;

   rstate_e               state_q, state_d;
   logic                  load;
   logic                  ar_hs;
   logic [IW-1:0]         free_idx;
   logic [N-1:0]          elig;
   logic [IW-1:0]         rr_idx;
   logic                  rr_hit;
   logic [IW-1:0]         win_idx;
   logic                  any_elig;
   logic                  win_last;
   logic [1:0]            win_lo;
   logic [PAY_W-1:0]      payload;

   // Ready comes only from registered occupancy, so a same-cycle free never reopens a full table.
   assign out_arready = aresetn & ~(&vld_q);
   assign ar_hs       = in_arvalid & out_arready;
   assign out_rvalid  = (state_q == R_BUSY);
   assign out_rresp   = 2'b00;

   // Lowest-index free slot, taken from state before any same-cycle free.
   always_comb begin
      free_idx = '0;
      for (int i = N-1; i >= 0; i--) begin
         if (!vld_q[i]) free_idx = IW'(i);
      end
   end

   // An entry may issue only when no older valid entry shares its ID.
   always_comb begin
      elig = '0;
      for (int i = 0; i < N; i++) begin
         elig[i] = vld_q[i];
         for (int j = 0; j < N; j++) begin
            if (vld_q[j] && older_q[j][i] && (id_q[j] == id_q[i])) elig[i] = 1'b0;
         end
      end
   end

   // Round-robin pick starting at ptr_q; scanning downward leaves ptr_q itself as highest priority.
   always_comb begin
      logic [IW-1:0] cand;
      cand   = '0;
      rr_idx = ptr_q;
      rr_hit = 1'b0;
      for (int k = N-1; k >= 0; k--) begin
         cand = ptr_q + IW'(k);
         if (elig[cand]) begin
            rr_idx = cand;
            rr_hit = 1'b1;
         end
      end
   end

`ifdef R_INTERLEAVE_EN
   assign win_idx  = rr_idx;
   assign any_elig = rr_hit;
`else
   logic          lock_vld_q;
   logic [IW-1:0] lock_idx_q;

   // A locked entry is always the oldest of its ID, so it stays eligible until its last beat.
   assign win_idx  = lock_vld_q ? lock_idx_q : rr_idx;
   assign any_elig = lock_vld_q | rr_hit;

   // Hold the arbiter on the current burst until its last beat is loaded.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         lock_vld_q <= 1'b0;
         lock_idx_q <= '0;
      end else if (load) begin
         lock_vld_q <= ~win_last;
         lock_idx_q <= win_idx;
      end
   end
`endif

   assign win_last = (cnt_q[win_idx] == len_q[win_idx]);
   assign win_lo   = 2'(win_idx);
   assign payload  = {id_q[win_idx], win_lo, cnt_q[win_idx]};

   // Output-register FSM: load a beat when empty, or on handshake for back-to-back issue.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      case (state_q)
         R_IDLE: begin
            if (any_elig) begin
               load    = 1'b1;
               state_d = R_BUSY;
            end
         end
         R_BUSY: begin
            if (in_rready) begin
               if (any_elig) load = 1'b1;
               else          state_d = R_IDLE;
            end
         end
         default: state_d = R_IDLE;
      endcase
   end

   // Output beat register and FSM state.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q   <= R_IDLE;
         out_rid   <= '0;
         out_rdata <= '0;
         out_rlast <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load) begin
            out_rid   <= id_q[win_idx];
            out_rdata <= AXI_DATA_W'(payload);
            out_rlast <= win_last;
         end
      end
   end

   // Table update: beat count/free on load, allocation on AR handshake (different slots by construction).
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         vld_q <= '0;
         ptr_q <= '0;
         for (int i = 0; i < N; i++) begin
            id_q[i]    <= '0;
            len_q[i]   <= '0;
            cnt_q[i]   <= '0;
            older_q[i] <= '0;
         end
      end else begin
         if (load) begin
            cnt_q[win_idx] <= cnt_q[win_idx] + 4'd1;
            ptr_q          <= win_idx + IW'(1);
            if (win_last) begin
               vld_q[win_idx] <= 1'b0;
               for (int j = 0; j < N; j++) older_q[j][win_idx] <= 1'b0;
            end
         end
         if (ar_hs) begin
            vld_q[free_idx]   <= 1'b1;
            id_q[free_idx]    <= in_arid;
            len_q[free_idx]   <= in_arlen;
            cnt_q[free_idx]   <= 4'd0;
            older_q[free_idx] <= '0;
            for (int j = 0; j < N; j++) older_q[j][free_idx] <= vld_q[j];
         end
      end
   end

   // Occupancy count of valid table entries.
   always_comb begin
      out_ostd_cnt = '0;
      for (int i = 0; i < N; i++) out_ostd_cnt = out_ostd_cnt + (IW+1)'(vld_q[i]);
   end

endmodule

// File: tb/tb_axi_slv_rd_scheduler.sv
// Bench for axi_slv_rd_scheduler: scoreboard of expected R beats fed by a request-level
// reference model (sequence numbers per burst, round-robin pointer, optional burst lock).
module tb_axi_slv_rd_scheduler;
   localparam int IDW = 4;
   localparam int DW  = 32;
   localparam int N   = 4;

   logic           aclk    = 1'b0;
   logic           aresetn = 1'b1;
   logic           in_arvalid = 1'b0;
   logic           out_arready;
   logic [IDW-1:0] in_arid = '0;
   logic [3:0]     in_arlen = '0;
   logic           out_rvalid;
   logic           in_rready = 1'b0;
   logic [IDW-1:0] out_rid;
   logic [DW-1:0]  out_rdata;
   logic [1:0]     out_rresp;
   logic           out_rlast;
   logic [2:0]     out_ostd_cnt;

   int checks = 0;
   int errors = 0;
   int rr_mode = 0;   // 0: rready low, 1: rready high, 2: random

   always #5 aclk = ~aclk;

   axi_slv_rd_scheduler #(.AXI_ID_W(IDW), .AXI_DATA_W(DW), .SLV_OSTDREQ_NUM(N)) dut (
      .aclk(aclk), .aresetn(aresetn), .in_arvalid(in_arvalid), .out_arready(out_arready),
      .in_arid(in_arid), .in_arlen(in_arlen), .out_rvalid(out_rvalid), .in_rready(in_rready),
      .out_rid(out_rid), .out_rdata(out_rdata), .out_rresp(out_rresp), .out_rlast(out_rlast),
      .out_ostd_cnt(out_ostd_cnt)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      int rid;
      int rdata;
      bit rlast;
   } beat_t;
   beat_t exp_q[$];

   // Reference model state: one record per outstanding burst.
   bit m_vld [N];
   int m_id  [N];
   int m_len [N];
   int m_cnt [N];
   int m_seq [N];
   int seq_ctr = 0;
   int m_rr    = 0;
   int m_lock  = -1;
   bit m_busy  = 1'b0;

   function automatic int m_count();
      int c = 0;
      for (int i = 0; i < N; i++) if (m_vld[i]) c++;
      return c;
   endfunction

   // A burst may issue when no earlier-accepted burst with the same ID is outstanding.
   function automatic bit m_elig(input int i);
      if (!m_vld[i]) return 1'b0;
      for (int j = 0; j < N; j++)
         if (m_vld[j] && m_id[j] == m_id[i] && m_seq[j] < m_seq[i]) return 1'b0;
      return 1'b1;
   endfunction

   always @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < N; i++) begin
            m_vld[i] = 1'b0; m_id[i] = 0; m_len[i] = 0; m_cnt[i] = 0; m_seq[i] = 0;
         end
         m_rr = 0; m_lock = -1; m_busy = 1'b0;
         exp_q.delete();
      end else begin
         int  fs, w;
         bit  ar_hs, hs_r, load, last;
         beat_t b;
         ar_hs = in_arvalid && (m_count() < N);
         hs_r  = m_busy && in_rready;
         fs = -1;
         for (int i = N-1; i >= 0; i--) if (!m_vld[i]) fs = i;
         w = -1;
`ifndef R_INTERLEAVE_EN
         if (m_lock >= 0) w = m_lock;
`endif
         for (int k = 0; k < N; k++)
            if (w < 0 && m_elig((m_rr + k) % N)) w = (m_rr + k) % N;
         load = (w >= 0) && (!m_busy || hs_r);
         if (load) begin
            last    = (m_cnt[w] == m_len[w]);
            b.rid   = m_id[w];
            b.rdata = (m_id[w] << 6) | ((w % 4) << 4) | m_cnt[w];
            b.rlast = last;
            exp_q.push_back(b);
            m_cnt[w]++;
            m_rr   = (w + 1) % N;
            m_busy = 1'b1;
            if (last) begin
               m_vld[w] = 1'b0;
               m_lock   = -1;
            end else begin
               m_lock   = w;
            end
         end else if (hs_r) begin
            m_busy = 1'b0;
         end
         if (ar_hs) begin
            m_vld[fs] = 1'b1; m_id[fs] = int'(in_arid); m_len[fs] = int'(in_arlen);
            m_cnt[fs] = 0;    m_seq[fs] = seq_ctr;      seq_ctr++;
         end
      end
   end

   // Monitor: compares DUT outputs with model each cycle; pops a beat when it is accepted.
   always @(negedge aclk) begin
      chk("rvalid", out_rvalid, m_busy);
      chk("arready", out_arready, aresetn && (m_count() < N));
      chk("ostd_cnt", out_ostd_cnt, m_count());
      if (!aresetn) begin
         chk("rst_rid", out_rid, 0);
         chk("rst_rdata", out_rdata, 0);
         chk("rst_rlast", out_rlast, 0);
      end
      if (out_rvalid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_beat", 1, 0);
         end else begin
            chk("rid", out_rid, exp_q[0].rid);
            chk("rdata", out_rdata, exp_q[0].rdata);
            chk("rlast", out_rlast, exp_q[0].rlast);
            chk("rresp", out_rresp, 0);
            if (in_rready) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      forever begin
         @(posedge aclk);
         #1;
         in_rready = (rr_mode == 1) || (rr_mode == 2 && $urandom_range(0, 1) == 1);
      end
   end

   task automatic ar(input int id, input int len);
      int n = 0;
      bit hs = 1'b0;
      in_arvalid = 1'b1;
      in_arid    = IDW'(id);
      in_arlen   = 4'(len);
      while (!hs && n < 500) begin
         @(negedge aclk);
         hs = out_arready;
         @(posedge aclk);
         #1;
         n++;
      end
      in_arvalid = 1'b0;
      chk("ar_accept", hs, 1);
   endtask

   task automatic drain();
      int n = 0;
      while ((m_count() != 0 || m_busy || exp_q.size() != 0) && n < 3000) begin
         @(posedge aclk);
         n++;
      end
      #1;
      chk("drain_done", n < 3000, 1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      #1 aresetn = 1'b0;
      #2;
      chk("reset_arready", out_arready, 0);
      chk("reset_rvalid", out_rvalid, 0);
      chk("reset_ostd", out_ostd_cnt, 0);
      repeat (2) @(posedge aclk);
      #2 aresetn = 1'b1;
      #1 chk("arready_after_release", out_arready, 1);
      @(posedge aclk);
      #1;

      // Basic burst, rready high.
      rr_mode = 1;
      ar(3, 2);
      drain();

      // Fill the table with ready low, then a fifth request must wait for a free.
      rr_mode = 0;
      ar(1, 1); ar(2, 1); ar(1, 1); ar(2, 1);
      chk("full_arready", out_arready, 0);
      chk("full_ostd", out_ostd_cnt, 4);
      fork
         ar(7, 0);
         begin
            repeat (6) @(posedge aclk);
            #1 rr_mode = 1;
         end
      join
      drain();

      // Same-ID ordering.
      rr_mode = 1;
      ar(5, 3); ar(5, 0);
      drain();

      // Two different IDs pending before rready rises.
      rr_mode = 0;
      ar(1, 3); ar(2, 3);
      repeat (2) @(posedge aclk);
      #1 rr_mode = 1;
      drain();

      // Long burst plus random traffic under random backpressure.
      rr_mode = 2;
      ar(4, 15);
      for (int i = 0; i < 30; i++) begin
         ar($urandom_range(0, 3), $urandom_range(0, 7));
         for (int g = 0; g < $urandom_range(0, 3); g++) begin
            @(posedge aclk);
            #1;
         end
      end
      drain();

      // Reset in the middle of a burst.
      rr_mode = 2;
      ar(6, 10);
      repeat (4) @(posedge aclk);
      #3 aresetn = 1'b0;
      #1;
      chk("midrst_rvalid", out_rvalid, 0);
      chk("midrst_ostd", out_ostd_cnt, 0);
      chk("midrst_arready", out_arready, 0);
      repeat (2) @(posedge aclk);
      #2 aresetn = 1'b1;
      @(posedge aclk);
      #1 rr_mode = 1;
      ar(0, 0);
      drain();

      chk("exp_q_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
